// File: rtl/ser_pkg.sv
// Shared types and configuration helpers for the bit-serializer control path.
package ser_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_SEL_WIDTH  = 3;

    // The select field must be able to address every bit of the word.
    function automatic bit sel_width_ok(input int data_width, input int sel_width);
        return (1 << sel_width) >= data_width;
    endfunction

endpackage

// File: rtl/bit_select_mux.sv
// Combinational bit picker: returns data[sel], with indices past the word reading as 0.
module bit_select_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [SEL_WIDTH-1:0]  i_sel,
    output logic                  o_bit
);

    localparam int EXT_W = 1 << SEL_WIDTH;

    logic [EXT_W-1:0] w_ext;

    assign w_ext = EXT_W'(i_data);
    assign o_bit = w_ext[i_sel];

endmodule

// File: rtl/bit_serializer_ctrl.sv
// Accepts a parallel word over valid/ready and emits it one bit per cycle,
// LSB- or MSB-first, with a per-word length and a flush abort.
module bit_serializer_ctrl
    import ser_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]  in_len,
    input  logic                  in_msb_first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic                  out_last,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  busy
);

    if (!sel_width_ok(DATA_WIDTH, SEL_WIDTH)) begin : g_cfg_err
        $error("bit_serializer_ctrl: SEL_WIDTH too narrow for DATA_WIDTH");
    end

    localparam logic [SEL_WIDTH-1:0] LEN_MAX = SEL_WIDTH'(DATA_WIDTH - 1);

    ser_state_e            r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic [SEL_WIDTH-1:0]  r_len, w_len_nxt;
    logic                  r_dir, w_dir_nxt;
    logic [SEL_WIDTH-1:0]  r_sel, w_sel_nxt;
    logic [SEL_WIDTH-1:0]  r_cnt, w_cnt_nxt;

    logic                  w_idle;
    logic                  w_shift;
    logic                  w_last;
    logic                  w_mux_bit;
    logic [SEL_WIDTH-1:0]  w_len_clamped;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_shift = (r_state == ST_SHIFT);
    assign w_last  = w_shift && (r_cnt == r_len);

    assign w_len_clamped = (32'(in_len) >= 32'(DATA_WIDTH)) ? LEN_MAX : in_len;

    bit_select_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_mux (
        .i_data (r_data),
        .i_sel  (r_sel),
        .o_bit  (w_mux_bit)
    );

    // flush masks acceptance in the same cycle it is seen
    assign in_ready  = w_idle && !flush;
    assign out_valid = w_shift;
    assign busy      = w_shift;
    assign out_bit   = w_shift && w_mux_bit;
    assign out_last  = w_last;
    assign sel       = r_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_len_nxt   = r_len;
        w_dir_nxt   = r_dir;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    w_data_nxt  = in_data;
                    w_len_nxt   = w_len_clamped;
                    w_dir_nxt   = in_msb_first;
                    w_sel_nxt   = in_msb_first ? w_len_clamped : '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_sel_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        w_sel_nxt = r_dir ? (r_sel - 1'b1) : (r_sel + 1'b1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_len   <= '0;
            r_dir   <= 1'b0;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_len   <= w_len_nxt;
            r_dir   <= w_dir_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: doc/bit_serializer_ctrl.md
Name: bit_serializer_ctrl

Overview:
- Sequencer that accepts a parallel word over a valid/ready handshake, then emits it one bit per cycle on a serial valid/ready output.
- Generates the select index that drives a bit-select mux, so it is the control path for the team's bit-selector datapath.
- Supports a configurable per-word length and LSB-first or MSB-first ordering.
- Sits between register-file/ALU-side producers and any bit-serial consumer, such as a shift-out port or a CRC unit.

Parameters:
- DATA_WIDTH, 8, width of the parallel input word (bits).
- SEL_WIDTH, 3, select/length field width; must satisfy 2^SEL_WIDTH >= DATA_WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of the word in flight.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_WIDTH  parallel word.
- in_len  in  SEL_WIDTH  number of bits to send minus 1.
- in_msb_first  in  1  1 = start at bit in_len and count down; 0 = start at bit 0 and count up.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  consumer takes the bit.
- out_bit  out  1  current serial bit.
- out_last  out  1  current bit is the final bit of the word.
- sel  out  SEL_WIDTH  current bit index (debug/observability).
- busy  out  1  high while a word is in flight.

Behaviour:
- Interface (already decided): one clock, `clock`; reset is synchronous and active-high, named `reset`.
- States: IDLE and SHIFT. All registers clear when reset is sampled high at a clock edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_bit=0, out_last=0, sel=0, busy=0, data_reg=0, len_reg=0, dir_reg=0, cnt=0.
- IDLE behaviour:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch in_data into data_reg, len into len_reg, direction into dir_reg.
  - Initialise sel = msb_first ? len : 0 and cnt=0, then go to SHIFT.
- Length clamp: if in_len >= DATA_WIDTH, len_reg = DATA_WIDTH-1.
- SHIFT outputs:
  - in_ready=0, out_valid=1, busy=1.
  - out_bit = data_reg[sel], combinational from registers via the mux sub-module.
  - out_last = (cnt == len_reg).
- SHIFT stepping:
  - On out_valid & out_ready with !out_last: cnt+1; sel+1 if dir_reg=0, else sel-1.
  - On out_valid & out_ready with out_last: go to IDLE; sel and cnt return to 0.
- Stall: while out_ready=0, all state, out_bit and out_last hold unchanged.
- Latency: word accepted in cycle T gives first out_valid in cycle T+1. A word of L+1 bits with out_ready held high occupies L+1 SHIFT cycles. in_ready reasserts in the cycle after the last handshake, so there is one IDLE bubble between words.
- No index wrap:
  - sel never underflows: MSB-first ends at sel=0.
  - sel never exceeds len_reg: LSB-first ends at sel=len_reg.
- Mux out of range: indices >= DATA_WIDTH (possible only when 2^SEL_WIDTH > DATA_WIDTH) read as 0.
- Single-bit word: in_len=0 gives one cycle with out_last=1 on the first bit.
- flush:
  - Has priority over the handshake; takes effect at the edge.
  - From SHIFT it forces IDLE, so out_valid=0 next cycle, and the partial word is discarded.
  - In IDLE it blocks acceptance that cycle (in_ready is forced to 0 while flush=1).
- reset has priority over flush. Reset mid-word behaves like flush and also clears the data registers.
- in_data, in_len and in_msb_first are ignored outside the accept handshake.

Decomposition:
- Shared package, ser_pkg:
  - state enum {ST_IDLE, ST_SHIFT}.
  - Default-width localparams.
  - An assertion helper checking 2^SEL_WIDTH >= DATA_WIDTH.
- One sub-module, bit_select_mux:
  - Purely combinational; parameterised DATA_WIDTH/SEL_WIDTH.
  - Zero-extends the data to 2^SEL_WIDTH bits and indexes with sel.
- The controller holds the FSM, counters and handshake logic.

Test Plan:
- Reset, then in_data=8'hB4, in_len=7, msb_first=0, out_ready=1 -> out_bit sequence 0,0,1,0,1,1,0,1 on 8 consecutive cycles; out_last only on the 8th; in_ready=1 the cycle after.
- in_data=8'hB4, in_len=7, msb_first=1 -> sequence 1,0,1,1,0,1,0,0; sel steps 7..0; no wrap to 7.
- in_data=8'h05, in_len=2, msb_first=0, with out_ready toggled 1,0,0,1,1 -> bits 1,0,1 emitted; outputs stable during the stalled cycles; 3 handshakes total.
- in_len=0 with in_data=8'h01 -> single bit 1 with out_last=1; back-to-back second word accepted exactly 2 cycles after the first accept.
- flush asserted after 3 bits of an 8-bit word -> out_valid=0 next cycle, busy=0, in_ready=1 one cycle after flush deasserts; the next word starts at its own bit 0.
- DATA_WIDTH=5, SEL_WIDTH=3, in_len=7 -> clamped to 4; exactly 5 bits emitted. Separately, reset asserted mid-word -> all outputs at their reset values the following cycle.
